datapath_byte_packer: RTL and testbench
=======================================

// Module: datapath_byte_packer
// PURPOSE
//  Packs the 8-bit SCSI byte stream into 32-bit longwords for the SCSI->memory FIFO.
//  Keeps the 2-bit byte pointer. BPTR drives datapath_24dec A/B and BPTR_EN drives its En, giving per-lane write strobes.
//  Has a one-longword output register, so bytes can keep filling while the FIFO stalls.
//  FLUSH pushes a partial longword at end of transfer, with byte enables marking the valid lanes.
// PARAMETERS
//  FLUSH_PAD   8'h00  value placed in the unfilled lanes of a flushed partial longword
//  BIG_ENDIAN  1      1: byte 0 goes to LW_OUT[31:24] (Amiga order). 0: byte 0 goes to LW_OUT[7:0]
// PORTS
//  CLK         in   1   system clock; the only clock
//  nRST        in   1   asynchronous, active-low reset
//  CLR         in   1   synchronous clear; highest priority after reset
//  BYTE_IN     in   8   SCSI data byte
//  BYTE_VALID  in   1   BYTE_IN is valid
//  BYTE_READY  out  1   packer accepts a byte; a byte transfers when BYTE_VALID && BYTE_READY
//  FLUSH       in   1   single-cycle request: emit any partial longword
//  FLUSH_DONE  out  1   single-cycle pulse when a flush is complete and the output is drained
//  LW_OUT      out  32  packed longword
//  LW_BE       out  4   lane enables (bit3 = lane 0); 4'b1111 for a full longword
//  LW_VALID    out  1   LW_OUT/LW_BE are valid
//  LW_READY    in   1   FIFO accepts; a longword transfers when LW_VALID && LW_READY
//  BPTR        out  2   current byte pointer; BPTR[1] = decoder A, BPTR[0] = decoder B
//  BPTR_EN     out  1   byte-accept strobe (BYTE_VALID && BYTE_READY); decoder En
//  EMPTY       out  1   no partial bytes held and LW_VALID is low
// BEHAVIOUR
//  Reset (nRST low) or CLR: BPTR=0, lane mask=0, assembly register=0, LW_OUT=0, LW_BE=0,
//   LW_VALID=0, FLUSH_DONE=0, state=RUN. Outputs: BYTE_READY=1, EMPTY=1.
//   CLR during a flush aborts the flush; no FLUSH_DONE is issued.
//  out_free = !LW_VALID || LW_READY. Lane n occupies LW_OUT[31-8n -: 8] when BIG_ENDIAN=1.
//  FSM states: RUN, FL_LOAD, FL_DRAIN, FL_DONE.
//  RUN: BYTE_READY = (BPTR!=3) || out_free.
//   On accept: store BYTE_IN in lane BPTR, set its mask bit, BPTR <= BPTR+1 (2-bit wrap 3->0).
//   On accept at BPTR==3: the full longword loads into the output register at the same edge.
//    LW_VALID=1 and LW_BE=4'b1111 from the next cycle (1-cycle latency). Mask clears. BPTR=0.
//   FLUSH in RUN -> FL_LOAD. A byte accepted in the same cycle as FLUSH is included in the flush.
//   A 4th byte plus FLUSH in the same cycle: the full longword loads and the flush then finds BPTR==0.
//  FL_LOAD: BYTE_READY=0.
//   If mask==0 -> FL_DRAIN.
//   Else wait for out_free, then load the partial longword: lanes with mask=0 get FLUSH_PAD, LW_BE=mask.
//    Clear the mask, BPTR=0, go to FL_DRAIN.
//  FL_DRAIN: BYTE_READY=0. Go to FL_DONE once !LW_VALID, or once LW_VALID && LW_READY.
//  FL_DONE: FLUSH_DONE=1 for exactly one cycle, BYTE_READY=0, then return to RUN.
//  FLUSH is ignored outside RUN.
//  A longword is always transferred when LW_VALID && LW_READY, in every state.
//  LW_OUT/LW_BE hold stable while LW_VALID && !LW_READY; there is no bubble when out_free.
//  Sustained throughput: 1 byte/cycle, provided LW_READY is high at least 1 cycle in 4.
//  EMPTY = (mask==0) && !LW_VALID; it is combinational from registers.
// STRUCTURE
//  Package datapath_pkg: FSM state enum (RUN/FL_LOAD/FL_DRAIN/FL_DONE), LANE_W=8, LANES=4.
//  Sub-module: one datapath_24dec instance (A=BPTR[1], B=BPTR[0], En=BPTR_EN).
//   Its D0..D3 outputs are the assembly-register lane write enables.
//  Everything else (pointer, mask, assembly/output registers, FSM) stays in this module.
// TESTING
//  1. Reset, then feed bytes 11,22,33,44 back-to-back with LW_READY=1
//     -> LW_OUT=32'h11223344, LW_BE=F, LW_VALID for 1 cycle, the cycle after byte 44.
//  2. LW_READY=0, feed 8 bytes -> first LW held stable; BYTE_READY drops at BPTR==3 of the second LW.
//     Raise LW_READY -> both LWs delivered in order, no byte lost.
//  3. Feed AA,BB then FLUSH -> LW_OUT=32'hAABB0000, LW_BE=4'b1100;
//     FLUSH_DONE 1 cycle after the LW handshake; BPTR=0, EMPTY=1.
//  4. FLUSH with EMPTY=1 -> no LW_VALID, FLUSH_DONE within 3 cycles.
//     Byte 55 at BPTR==3 with FLUSH in the same cycle -> full LW, no partial LW.
//  5. Drop nRST mid-flush (partial LW pending, LW_READY=0)
//     -> all outputs at reset values immediately; no FLUSH_DONE afterwards.
//  6. BIG_ENDIAN=0, bytes 11,22,33 + FLUSH -> LW_OUT=32'h00332211, LW_BE=4'b0111.
//     Also check BPTR_EN/BPTR against the D0..D3 strobes every accept.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and sizes for the SCSI byte-to-longword packer.
// No logic: enum and lane geometry only.
// Not applicable (no datapath in a package).
package datapath_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    // Flush sequencing: fill lanes in RUN, emit partial, wait for drain, pulse done
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FL_LOAD  = 2'd1,
        FL_DRAIN = 2'd2,
        FL_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/datapath_24dec.sv
// 2-to-4 decoder with enable; turns the byte pointer into per-lane write strobes.
// Latency: combinational.
// Backpressure: none; En is already qualified by the byte handshake.
module datapath_24dec (
    input  logic A,
    input  logic B,
    input  logic En,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3
);

    assign D0 = En & ~A & ~B;
    assign D1 = En & ~A &  B;
    assign D2 = En &  A & ~B;
    assign D3 = En &  A &  B;

endmodule

// File: rtl/datapath_byte_packer.sv
// Packs the SCSI byte stream into 32-bit longwords with a one-deep output register.
// Latency: a longword is valid the cycle after its 4th byte (or after the flush load).
// Backpressure: bytes 0..2 always accepted; byte 3 held off until the output register is free.
module datapath_byte_packer
    import datapath_pkg::*;
#(
    parameter logic [7:0] FLUSH_PAD  = 8'h00,
    parameter bit         BIG_ENDIAN = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        CLR,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    input  logic        FLUSH,
    output logic        FLUSH_DONE,
    output logic [31:0] LW_OUT,
    output logic [3:0]  LW_BE,
    output logic        LW_VALID,
    input  logic        LW_READY,
    output logic [1:0]  BPTR,
    output logic        BPTR_EN,
    output logic        EMPTY
);

    state_e                        state_q, state_d;
    logic [1:0]                    bptr_q, bptr_d;
    logic [LANES-1:0]              mask_q, mask_d;   // indexed by lane number
    logic [LANES-1:0][LANE_W-1:0]  asm_q, asm_d;     // indexed by lane number
    logic [31:0]                   lw_q, lw_d;
    logic [3:0]                    be_q, be_d;
    logic                          vld_q, vld_d;

    logic                          out_free;
    logic                          byte_rdy;
    logic                          accept;
    logic [LANES-1:0]              lane_we;

    // Place lanes into the longword; unfilled lanes get the pad byte.
    function automatic logic [31:0] pack_lw(input logic [LANES-1:0][LANE_W-1:0] lanes,
                                            input logic [LANES-1:0] m);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int n = 0; n < LANES; n++) begin
            b = m[n] ? lanes[n] : FLUSH_PAD;
            if (BIG_ENDIAN) w[31-8*n -: 8] = b;
            else            w[8*n +: 8]    = b;
        end
        return w;
    endfunction

    // Byte enables follow the byte position in LW_OUT, so map lanes the same way as data.
    function automatic logic [3:0] be_map(input logic [LANES-1:0] m);
        return BIG_ENDIAN ? {m[0], m[1], m[2], m[3]} : m;
    endfunction

    assign out_free = !vld_q || LW_READY;
    assign byte_rdy = (state_q == RUN) && ((bptr_q != 2'd3) || out_free);
    assign accept   = BYTE_VALID && byte_rdy;

    datapath_24dec u_dec (
        .A  (bptr_q[1]),
        .B  (bptr_q[0]),
        .En (accept),
        .D0 (lane_we[0]),
        .D1 (lane_we[1]),
        .D2 (lane_we[2]),
        .D3 (lane_we[3])
    );

    // Next-state: lane fill, output register load/drain and the flush sequence
    always_comb begin
        state_d = state_q;
        bptr_d  = bptr_q;
        mask_d  = mask_q;
        asm_d   = asm_q;
        lw_d    = lw_q;
        be_d    = be_q;
        vld_d   = vld_q;

        // Handshake retires the held longword in every state; a same-edge load overrides.
        if (vld_q && LW_READY) vld_d = 1'b0;

        for (int n = 0; n < LANES; n++) begin
            if (lane_we[n]) begin
                asm_d[n]  = BYTE_IN;
                mask_d[n] = 1'b1;
            end
        end
        if (accept) bptr_d = bptr_q + 2'd1;

        case (state_q)
            RUN: begin
                // 4th byte completes the longword; pointer wraps to 0 on its own
                if (accept && (bptr_q == 2'd3)) begin
                    lw_d   = pack_lw(asm_d, 4'b1111);
                    be_d   = 4'b1111;
                    vld_d  = 1'b1;
                    mask_d = '0;
                end
                if (FLUSH) state_d = FL_LOAD;
            end
            FL_LOAD: begin
                if (mask_q == '0) begin
                    state_d = FL_DRAIN;
                end else if (out_free) begin
                    lw_d    = pack_lw(asm_q, mask_q);
                    be_d    = be_map(mask_q);
                    vld_d   = 1'b1;
                    mask_d  = '0;
                    bptr_d  = 2'd0;
                    state_d = FL_DRAIN;
                end
            end
            FL_DRAIN: begin
                if (out_free) state_d = FL_DONE;
            end
            FL_DONE: begin
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State registers; CLR behaves like reset and aborts any flush in progress
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            bptr_q  <= '0;
            mask_q  <= '0;
            asm_q   <= '0;
            lw_q    <= '0;
            be_q    <= '0;
            vld_q   <= 1'b0;
        end else if (CLR) begin
            state_q <= RUN;
            bptr_q  <= '0;
            mask_q  <= '0;
            asm_q   <= '0;
            lw_q    <= '0;
            be_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bptr_q  <= bptr_d;
            mask_q  <= mask_d;
            asm_q   <= asm_d;
            lw_q    <= lw_d;
            be_q    <= be_d;
            vld_q   <= vld_d;
        end
    end

    assign BYTE_READY = byte_rdy;
    assign BPTR_EN    = accept;
    assign BPTR       = bptr_q;
    assign LW_OUT     = lw_q;
    assign LW_BE      = be_q;
    assign LW_VALID   = vld_q;
    assign FLUSH_DONE = (state_q == FL_DONE);
    assign EMPTY      = (mask_q == '0) && !vld_q;

endmodule

// File: tb/tb_datapath_byte_packer.sv
// Directed bench for the byte packer: big-endian instance for most steps,
// little-endian instance for the lane-order / byte-enable step.
// Inputs driven 1 time unit after the rising edge; outputs sampled before the next edge.
module tb_datapath_byte_packer;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRST, CLR;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID, FLUSH, LW_READY;
    logic        BYTE_READY, FLUSH_DONE, LW_VALID, BPTR_EN, EMPTY;
    logic [31:0] LW_OUT;
    logic [3:0]  LW_BE;
    logic [1:0]  BPTR;

    logic [7:0]  le_byte_in;
    logic        le_byte_valid, le_flush, le_lw_ready;
    logic        le_byte_ready, le_flush_done, le_lw_valid, le_bptr_en, le_empty;
    logic [31:0] le_lw_out;
    logic [3:0]  le_lw_be;
    logic [1:0]  le_bptr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_ptr  = 2'd0;
    int          done_cnt, vld_cnt;
    logic [7:0]  le_bytes [3] = '{8'h11, 8'h22, 8'h33};

    datapath_byte_packer #(.FLUSH_PAD(8'h00), .BIG_ENDIAN(1'b1)) u_be (
        .CLK(CLK), .nRST(nRST), .CLR(CLR),
        .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
        .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE),
        .LW_OUT(LW_OUT), .LW_BE(LW_BE), .LW_VALID(LW_VALID), .LW_READY(LW_READY),
        .BPTR(BPTR), .BPTR_EN(BPTR_EN), .EMPTY(EMPTY)
    );

    datapath_byte_packer #(.FLUSH_PAD(8'h00), .BIG_ENDIAN(1'b0)) u_le (
        .CLK(CLK), .nRST(nRST), .CLR(CLR),
        .BYTE_IN(le_byte_in), .BYTE_VALID(le_byte_valid), .BYTE_READY(le_byte_ready),
        .FLUSH(le_flush), .FLUSH_DONE(le_flush_done),
        .LW_OUT(le_lw_out), .LW_BE(le_lw_be), .LW_VALID(le_lw_valid), .LW_READY(le_lw_ready),
        .BPTR(le_bptr), .BPTR_EN(le_bptr_en), .EMPTY(le_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One accepted byte on the big-endian instance, with pointer and lane-strobe checks
    task automatic send_byte(input logic [7:0] b);
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        #1;
        chk("byte_ready", BYTE_READY, 1);
        chk("bptr", BPTR, exp_ptr);
        chk("bptr_en", BPTR_EN, 1);
        chk("lane_strobe", {u_be.u_dec.D3, u_be.u_dec.D2, u_be.u_dec.D1, u_be.u_dec.D0},
            4'b0001 << exp_ptr);
        @(posedge CLK);
        #1;
        BYTE_VALID = 1'b0;
        exp_ptr    = exp_ptr + 2'd1;
    endtask

    initial begin
        nRST = 1'b0; CLR = 1'b0;
        BYTE_IN = '0; BYTE_VALID = 1'b0; FLUSH = 1'b0; LW_READY = 1'b1;
        le_byte_in = '0; le_byte_valid = 1'b0; le_flush = 1'b0; le_lw_ready = 1'b1;
        #12;
        nRST = 1'b1;

        // Reset values
        chk("rst_byte_ready", BYTE_READY, 1);
        chk("rst_empty", EMPTY, 1);
        chk("rst_lw_valid", LW_VALID, 0);
        chk("rst_lw_out", LW_OUT, 32'h0);
        chk("rst_lw_be", LW_BE, 4'h0);
        chk("rst_bptr", BPTR, 2'd0);
        chk("rst_flush_done", FLUSH_DONE, 0);
        tick();

        // 1: four bytes back-to-back, output ready
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("t1_lw_out", LW_OUT, 32'h11223344);
        chk("t1_lw_be", LW_BE, 4'hF);
        chk("t1_lw_valid", LW_VALID, 1);
        tick();
        chk("t1_lw_valid_drop", LW_VALID, 0);
        chk("t1_empty", EMPTY, 1);

        // 2: output stalled, second longword backs up at lane 3
        LW_READY = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t2_lw1", LW_OUT, 32'h01020304);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
        chk("t2_lw1_hold", LW_OUT, 32'h01020304);
        chk("t2_lw1_hold_vld", LW_VALID, 1);
        BYTE_IN = 8'h08; BYTE_VALID = 1'b1;
        #1;
        chk("t2_stall_ready", BYTE_READY, 0);
        chk("t2_stall_bptr_en", BPTR_EN, 0);
        tick();
        chk("t2_stall_bptr", BPTR, 2'd3);
        chk("t2_lw1_still", LW_OUT, 32'h01020304);
        LW_READY = 1'b1;
        #1;
        chk("t2_release_ready", BYTE_READY, 1);
        tick();
        BYTE_VALID = 1'b0;
        exp_ptr = 2'd0;
        chk("t2_lw2", LW_OUT, 32'h05060708);
        chk("t2_lw2_vld", LW_VALID, 1);
        chk("t2_bptr_wrap", BPTR, 2'd0);
        tick();
        chk("t2_drained", LW_VALID, 0);

        // 3: partial flush of two bytes
        send_byte(8'hAA); send_byte(8'hBB);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("t3_load_ready", BYTE_READY, 0);
        tick();
        chk("t3_lw_out", LW_OUT, 32'hAABB0000);
        chk("t3_lw_be", LW_BE, 4'hC);
        chk("t3_lw_vld", LW_VALID, 1);
        chk("t3_done_early", FLUSH_DONE, 0);
        tick();
        chk("t3_done", FLUSH_DONE, 1);
        chk("t3_bptr", BPTR, 2'd0);
        chk("t3_empty", EMPTY, 1);
        tick();
        chk("t3_done_pulse", FLUSH_DONE, 0);
        exp_ptr = 2'd0;

        // 4a: flush while empty
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        done_cnt = 0; vld_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (FLUSH_DONE) done_cnt++;
            if (LW_VALID) vld_cnt++;
            tick();
        end
        chk("t4_empty_done", done_cnt, 1);
        chk("t4_empty_novld", vld_cnt, 0);

        // 4b: 4th byte and flush in the same cycle
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        BYTE_IN = 8'h55; BYTE_VALID = 1'b1; FLUSH = 1'b1;
        #1;
        chk("t4_b55_ready", BYTE_READY, 1);
        tick();
        BYTE_VALID = 1'b0; FLUSH = 1'b0;
        exp_ptr = 2'd0;
        chk("t4_full_lw", LW_OUT, 32'h01020355);
        chk("t4_full_be", LW_BE, 4'hF);
        done_cnt = 0; vld_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (FLUSH_DONE) done_cnt++;
            if (LW_VALID) vld_cnt++;
        end
        chk("t4_full_done", done_cnt, 1);
        chk("t4_no_partial", vld_cnt, 0);
        chk("t4_empty", EMPTY, 1);

        // 5: reset during a stalled flush
        LW_READY = 1'b0;
        send_byte(8'hCC); send_byte(8'hDD);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        tick();
        chk("t5_partial_vld", LW_VALID, 1);
        chk("t5_partial_lw", LW_OUT, 32'hCCDD0000);
        nRST = 1'b0;
        #1;
        chk("t5_rst_vld", LW_VALID, 0);
        chk("t5_rst_lw", LW_OUT, 32'h0);
        chk("t5_rst_be", LW_BE, 4'h0);
        chk("t5_rst_empty", EMPTY, 1);
        chk("t5_rst_ready", BYTE_READY, 1);
        tick();
        nRST = 1'b1;
        exp_ptr = 2'd0;
        LW_READY = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (FLUSH_DONE) done_cnt++;
        end
        chk("t5_no_done", done_cnt, 0);

        // Synchronous clear drops a held byte
        send_byte(8'hEE);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        exp_ptr = 2'd0;
        chk("clr_bptr", BPTR, 2'd0);
        chk("clr_empty", EMPTY, 1);

        // 6: little-endian lane order and byte enables
        for (int i = 0; i < 3; i++) begin
            le_byte_in = le_bytes[i];
            le_byte_valid = 1'b1;
            tick();
        end
        le_byte_valid = 1'b0;
        le_flush = 1'b1;
        tick();
        le_flush = 1'b0;
        tick();
        chk("t6_le_lw", le_lw_out, 32'h00332211);
        chk("t6_le_be", le_lw_be, 4'h7);
        chk("t6_le_vld", le_lw_valid, 1);
        tick();
        chk("t6_le_done", le_flush_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
